// File: rtl/servo_pulse_decoder.sv
// Measures the high time of an RC-servo PWM pulse and decodes it into direction / speed_angle.
// Optional: define AVG_FILTER_EN to average each accepted width with the previous raw width.
module servo_pulse_decoder #(
    parameter int CLK_DIV       = 391,
    parameter int CENTER        = 384,
    parameter int MIN_TICKS     = 64,
    parameter int MAX_TICKS     = 768,
    parameter int TIMEOUT_TICKS = 8192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pwm_in,
    input  logic        servo_select,
    output logic        direction,
    output logic [5:0]  speed_angle,
    output logic [7:0]  debug_led,
    output logic [11:0] pulse_width,
    output logic        sample_valid,
    output logic        pulse_error,
    output logic        signal_lost
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TO_LIMIT    = TW'(TIMEOUT_TICKS);
    localparam logic [TW-1:0] TO_PRELIMIT = TW'(TIMEOUT_TICKS - 1);
    localparam logic [11:0]   WIDTH_SAT   = 12'hFFF;

    typedef enum logic [2:0] {
        WAIT_LOW,
        WAIT_RISE,
        MEASURE,
        DECODE,
        REJECT
    } state_t;

    state_t state_q, state_d;

    logic pwm_meta, pwm_sync, pwm_prev;
    logic rise, fall, tick;
    logic [PW-1:0] presc;
    logic [11:0]   width;
    logic [TW-1:0] to_cnt;
    logic          to_expire;
    logic          in_range, accept;
    logic          select_q;

    logic [12:0] w_dec, mag, mag_shift;
    logic        dir_d;
    logic [5:0]  speed_d;

    // NOTE: the synchronizer has no reset so that, while reset is held, it fills with
    // the live pin level; a pulse already high at reset release is then never seen as a rise.
    always_ff @(posedge clk) begin
        pwm_meta <= pwm_in;
        pwm_sync <= pwm_meta;
        pwm_prev <= pwm_sync;
    end

    assign rise = pwm_sync & ~pwm_prev;
    assign fall = ~pwm_sync & pwm_prev;
    assign tick = (presc == PRESC_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (rise || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A rise clears both counters even if a tick lands on the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            width  <= '0;
            to_cnt <= '0;
        end else begin
            if (rise) begin
                width <= '0;
            end else if (state_q == MEASURE && tick && width != WIDTH_SAT) begin
                width <= width + 1'b1;
            end
            if (rise) begin
                to_cnt <= '0;
            end else if (tick && to_cnt != TO_LIMIT) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign to_expire = tick && !rise && (to_cnt == TO_PRELIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    // The range check applies to the raw measurement so a glitch can never be averaged in.
    assign in_range = (width >= 12'(MIN_TICKS)) && (width <= 12'(MAX_TICKS));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            WAIT_LOW:  if (!pwm_sync) state_d = WAIT_RISE;
            WAIT_RISE: if (rise) state_d = MEASURE;
            MEASURE: begin
                if (fall) begin
                    state_d = DECODE;
                end else if (width > 12'(MAX_TICKS)) begin
                    state_d = REJECT;
                end
            end
            DECODE: begin
                if (in_range) begin
                    accept  = 1'b1;
                    state_d = WAIT_RISE;
                end else begin
                    state_d = REJECT;
                end
            end
            REJECT:  state_d = WAIT_LOW;
            default: state_d = WAIT_LOW;
        endcase
    end

`ifdef AVG_FILTER_EN
    logic [11:0] prev_raw;
    logic [12:0] avg_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_raw <= '0;
        end else if (accept) begin
            prev_raw <= width;
        end
    end

    // The first sample after reset or a lost signal is taken unaveraged.
    always_comb begin
        avg_sum = {1'b0, prev_raw} + {1'b0, width} + 13'd1;
        w_dec   = signal_lost ? {1'b0, width} : (avg_sum >> 1);
    end
`else
    assign w_dec = {1'b0, width};
`endif

    always_comb begin
        dir_d = 1'b0;
        mag   = '0;
        if (w_dec >= 13'(CENTER)) begin
            dir_d = 1'b1;
            mag   = w_dec - 13'(CENTER);
        end else begin
            mag   = 13'(CENTER) - w_dec;
        end
        mag_shift = servo_select ? (mag >> 2) : (mag >> 1);
        speed_d   = (mag_shift > 13'd63) ? 6'd63 : mag_shift[5:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            direction    <= 1'b0;
            speed_angle  <= '0;
            pulse_width  <= '0;
            select_q     <= 1'b0;
            sample_valid <= 1'b0;
            pulse_error  <= 1'b0;
            signal_lost  <= 1'b1;
        end else begin
            sample_valid <= accept;
            pulse_error  <= (state_q == REJECT);
            if (accept) begin
                direction   <= dir_d;
                speed_angle <= speed_d;
                pulse_width <= w_dec[11:0];
                select_q    <= servo_select;
                signal_lost <= 1'b0;
            end else if (to_expire) begin
                signal_lost <= 1'b1;
            end
        end
    end

    assign debug_led = {select_q, direction, speed_angle};

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed bench for servo_pulse_decoder: vector table of pulses plus reset/timeout sequences.
module tb_servo_pulse_decoder;

    localparam int CLK_DIV = 3;
    localparam int TO_T    = 2048;
    localparam int GAP     = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic        pwm_in;
    logic        servo_select;
    logic        direction;
    logic [5:0]  speed_angle;
    logic [7:0]  debug_led;
    logic [11:0] pulse_width;
    logic        sample_valid;
    logic        pulse_error;
    logic        signal_lost;

    int n_checks = 0;
    int n_fail   = 0;

    servo_pulse_decoder #(
        .CLK_DIV(CLK_DIV), .CENTER(384), .MIN_TICKS(64), .MAX_TICKS(768), .TIMEOUT_TICKS(TO_T)
    ) dut (
        .clk(clk), .reset(reset), .pwm_in(pwm_in), .servo_select(servo_select),
        .direction(direction), .speed_angle(speed_angle), .debug_led(debug_led),
        .pulse_width(pulse_width), .sample_valid(sample_valid), .pulse_error(pulse_error),
        .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ticks;
        logic        sel;
        int          n_valid;
        int          n_err;
        logic        dir;
        logic [5:0]  spd;
        logic [11:0] pw;
        logic [7:0]  dbg;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int ticks, logic sel, int nv, int ne, logic dir,
                                logic [5:0] spd, logic [11:0] pw, logic [7:0] dbg);
        vec_t v;
        v.ticks = ticks; v.sel = sel; v.n_valid = nv; v.n_err = ne;
        v.dir = dir; v.spd = spd; v.pw = pw; v.dbg = dbg;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Drives one pulse of 'ticks' ticks followed by GAP low ticks, counting output strobes.
    task automatic send_pulse(input int ticks, input logic sel, output int nv, output int ne);
        nv = 0;
        ne = 0;
        @(negedge clk);
        servo_select = sel;
        pwm_in       = 1'b1;
        for (int i = 0; i < (ticks + GAP) * CLK_DIV; i++) begin
            if (i == ticks * CLK_DIV) pwm_in = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (sample_valid) nv++;
            if (pulse_error) ne++;
        end
    endtask

    task automatic check_outputs(input string tag, input logic dir, input logic [5:0] spd,
                                 input logic [11:0] pw, input logic [7:0] dbg);
        check({tag, " direction"}, 32'(direction), 32'(dir));
        check({tag, " speed_angle"}, 32'(speed_angle), 32'(spd));
        check({tag, " pulse_width"}, 32'(pulse_width), 32'(pw));
        check({tag, " debug_led"}, 32'(debug_led), 32'(dbg));
    endtask

    initial begin
        int nv, ne;
        int n_valid_seq;
        reset        = 1'b1;
        pwm_in       = 1'b0;
        servo_select = 1'b0;

`ifdef AVG_FILTER_EN
        vecs.push_back(mk(384, 1'b0, 1, 0, 1'b1, 6'd0,  12'd384, 8'h40));
        vecs.push_back(mk(420, 1'b0, 1, 0, 1'b1, 6'd9,  12'd402, 8'h49));
        vecs.push_back(mk(40,  1'b0, 0, 1, 1'b1, 6'd9,  12'd402, 8'h49));
        vecs.push_back(mk(300, 1'b1, 1, 0, 1'b0, 6'd6,  12'd360, 8'h86));
        vecs.push_back(mk(900, 1'b0, 0, 1, 1'b0, 6'd6,  12'd360, 8'h86));
        vecs.push_back(mk(64,  1'b0, 1, 0, 1'b0, 6'd63, 12'd182, 8'h3F));
`else
        vecs.push_back(mk(384, 1'b0, 1, 0, 1'b1, 6'd0,  12'd384, 8'h40));
        vecs.push_back(mk(256, 1'b0, 1, 0, 1'b0, 6'd63, 12'd256, 8'h3F));
        vecs.push_back(mk(448, 1'b1, 1, 0, 1'b1, 6'd16, 12'd448, 8'hD0));
        vecs.push_back(mk(40,  1'b0, 0, 1, 1'b1, 6'd16, 12'd448, 8'hD0));
        vecs.push_back(mk(900, 1'b0, 0, 1, 1'b1, 6'd16, 12'd448, 8'hD0));
        vecs.push_back(mk(64,  1'b0, 1, 0, 1'b0, 6'd63, 12'd64,  8'h3F));
        vecs.push_back(mk(768, 1'b1, 1, 0, 1'b1, 6'd63, 12'd768, 8'hFF));
        vecs.push_back(mk(63,  1'b1, 0, 1, 1'b1, 6'd63, 12'd768, 8'hFF));
        vecs.push_back(mk(769, 1'b0, 0, 1, 1'b1, 6'd63, 12'd768, 8'hFF));
        vecs.push_back(mk(383, 1'b0, 1, 0, 1'b0, 6'd0,  12'd383, 8'h00));
        vecs.push_back(mk(511, 1'b1, 1, 0, 1'b1, 6'd31, 12'd511, 8'hDF));
        vecs.push_back(mk(385, 1'b1, 1, 0, 1'b1, 6'd0,  12'd385, 8'hC0));
`endif

        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset sample_valid", 32'(sample_valid), 32'd0);
        check("reset pulse_error", 32'(pulse_error), 32'd0);
        check("reset signal_lost", 32'(signal_lost), 32'd1);
        check_outputs("reset", 1'b0, 6'd0, 12'd0, 8'h00);

        foreach (vecs[i]) begin
            send_pulse(vecs[i].ticks, vecs[i].sel, nv, ne);
            check($sformatf("v%0d valid_count", i), 32'(nv), 32'(vecs[i].n_valid));
            check($sformatf("v%0d error_count", i), 32'(ne), 32'(vecs[i].n_err));
            check($sformatf("v%0d signal_lost", i), 32'(signal_lost), 32'd0);
            check_outputs($sformatf("v%0d", i), vecs[i].dir, vecs[i].spd, vecs[i].pw, vecs[i].dbg);
        end

        // Reset in the middle of a pulse; the pulse is still high when reset releases.
        @(negedge clk);
        servo_select = 1'b0;
        pwm_in       = 1'b1;
        repeat (100 * CLK_DIV) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        nv = 0;
        ne = 0;
        for (int i = 0; i < 250 * CLK_DIV; i++) begin
            if (i == 200 * CLK_DIV) pwm_in = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (sample_valid) nv++;
            if (pulse_error) ne++;
        end
        check("midreset valid_count", 32'(nv), 32'd0);
        check("midreset error_count", 32'(ne), 32'd0);
        check("midreset signal_lost", 32'(signal_lost), 32'd1);
        check_outputs("midreset", 1'b0, 6'd0, 12'd0, 8'h00);

        // Timed 500-tick pulse: decode latency, then loss of signal after TO_T ticks from the rise.
        n_valid_seq = 0;
        ne = 0;
        pwm_in = 1'b1;
        for (int n = 1; n <= TO_T * CLK_DIV + 3; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (sample_valid) n_valid_seq++;
            if (pulse_error) ne++;
            if (n == 500 * CLK_DIV + 3) check("latency valid_early", 32'(sample_valid), 32'd0);
            if (n == 500 * CLK_DIV + 4) check("latency valid_on_time", 32'(sample_valid), 32'd1);
            if (n == TO_T * CLK_DIV + 2) check("timeout lost_before", 32'(signal_lost), 32'd0);
            if (n == TO_T * CLK_DIV + 3) check("timeout lost_after", 32'(signal_lost), 32'd1);
            if (n == 500 * CLK_DIV) pwm_in = 1'b0;
        end
        check("timeout valid_count", 32'(n_valid_seq), 32'd1);
        check("timeout error_count", 32'(ne), 32'd0);
        check_outputs("timeout_hold", 1'b1, 6'd58, 12'd500, 8'h7A);

        send_pulse(320, 1'b1, nv, ne);
        check("recover valid_count", 32'(nv), 32'd1);
        check("recover error_count", 32'(ne), 32'd0);
        check("recover signal_lost", 32'(signal_lost), 32'd0);
        check_outputs("recover", 1'b0, 6'd16, 12'd320, 8'h90);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/servo_pulse_decoder.md
Name: servo_pulse_decoder

Overview:
- Receive-side counterpart of the servo PWM generator. Measures the high-time of an incoming RC-servo PWM pulse and decodes it back into the servo control-register fields: direction, 6-bit speed/angle, servo select echo.
- Used for loopback verification of the servo outputs and for reading an external RC receiver channel. Results are presented to the PicoBlaze port logic.

Parameters:
- CLK_DIV, 391, clocks per measurement tick (~3.9 us at 100 MHz). Must be ≥ 2.
- CENTER, 384, tick count that decodes to zero speed/angle.
- MIN_TICKS, 64, shortest accepted pulse, in ticks.
- MAX_TICKS, 768, longest accepted pulse, in ticks.
- TIMEOUT_TICKS, 8192, ticks without a rising edge before the signal is declared lost.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pwm_in  in  1  asynchronous servo pulse input
- servo_select  in  1  decode scaling: 0 = full-rotation (shift 1), 1 = normal (shift 2)
- direction  out  1  decoded direction bit
- speed_angle  out  6  decoded magnitude
- debug_led  out  8  {servo_select, direction, speed_angle}
- pulse_width  out  12  last accepted width, in ticks
- sample_valid  out  1  one-clock strobe when new outputs are loaded
- pulse_error  out  1  one-clock strobe when a pulse is rejected
- signal_lost  out  1  level; high while no rising edge has been seen within TIMEOUT_TICKS

Behaviour:
- Reset values:
  - direction = 0, speed_angle = 0, pulse_width = 0.
  - sample_valid = 0, pulse_error = 0, signal_lost = 1.
  - FSM state = WAIT_LOW. All counters = 0.
- Input synchronisation: pwm_in passes through a 2-FF synchronizer, then a third register for edge detection.
  - rise = sync & ~prev; fall = ~sync & prev.
- Tick prescaler: free-running count 0..CLK_DIV-1. tick is asserted when the count equals CLK_DIV-1.
  - The prescaler and the width counter are both cleared on rise. This makes a high time of exactly K*CLK_DIV clocks measure exactly K.
- Width counter: 12-bit. Increments on tick while in MEASURE. Saturates at 4095, no wrap.
- FSM:
  - WAIT_LOW: wait for sync == 0. Entered after reset so that a pulse already in progress is never measured. Goes to WAIT_RISE.
  - WAIT_RISE: on rise → MEASURE (clear width counter and prescaler).
  - MEASURE: on fall → DECODE. If width exceeds MAX_TICKS while still high → REJECT (stuck-high protection).
  - DECODE (1 cycle): range-check W. If MIN_TICKS ≤ W ≤ MAX_TICKS, load the outputs, pulse sample_valid, go to WAIT_RISE. Otherwise → REJECT.
  - REJECT (1 cycle): pulse pulse_error, hold all data outputs, go to WAIT_LOW.
- Decode arithmetic (W = accepted width):
  - W ≥ CENTER: direction = 1, mag = W − CENTER. Otherwise direction = 0, mag = CENTER − W.
  - speed_angle = min(mag >> (servo_select ? 2 : 1), 63). Saturating, never wraps.
  - pulse_width = W.
- Latency: fall detected on edge-register cycle N → outputs and sample_valid registered at cycle N+2.
- Timeout counter:
  - Counts ticks and is cleared on every rise.
  - Reaching TIMEOUT_TICKS sets signal_lost. The counter saturates there.
  - signal_lost clears on the first sample_valid. Data outputs hold their last value while signal_lost is high.
- Simultaneous events: a rise in the same cycle as a tick clears the counters; the clear takes priority.
- Reset mid-pulse: return to WAIT_LOW; the partial pulse is discarded and no error is flagged.
- servo_select is sampled in DECODE only.

Optional Feature:
- AVG_FILTER_EN:
  - When defined, W used for decode = (previous accepted width + current width + 1) >> 1, computed 13 bits wide.
  - The first accepted sample after reset or after signal_lost is used unaveraged.
  - pulse_width reports the averaged value.
  - Latency is unchanged (N+2).
- Without the macro, W = raw measured width.

Test Plan:
- CLK_DIV = 3. Pulse high 384*3 clocks, period 4096 ticks, servo_select = 0 → sample_valid once; direction = 1, speed_angle = 0, pulse_width = 384; signal_lost falls.
- High 256*3 clocks, servo_select = 0 → direction = 0, speed_angle = 63 (128 >> 1 saturates to 63). Then high 448 ticks, servo_select = 1 → direction = 1, speed_angle = 16.
- High 40 ticks, then high 900 ticks → pulse_error strobes twice (second strobe while still high, at tick 769); no sample_valid; outputs hold previous values.
- pwm_in already high when reset deasserts → the first partial pulse is ignored; only the next full pulse (e.g. 500 ticks) decodes, to direction = 1, speed_angle = 58 (select 0).
- Stop the pulses after a valid sample → signal_lost = 1 exactly TIMEOUT_TICKS ticks after the last rise; data holds; the next valid pulse clears it.
- AVG_FILTER_EN: pulses 384 then 420 ticks → second decode W = 402, pulse_width = 402, speed_angle = 9 (select 0).
